// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and constants for the shared-register write arbiter.
package shared_reg_arbiter_pkg;

  typedef enum logic {IDLE, GRANT} state_t;

  localparam int DEF_MAX_BURST = 4;

  // Bits needed to hold an index in 0..n-1 (at least 1).
  function automatic int idx_w(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Requester-side bus of the shared-register arbiter.
interface shared_reg_arbiter_if
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  localparam int IW = idx_w(N_REQ);

  logic [N_REQ-1:0]       req;
  logic [N_REQ-1:0]       lock;
  logic [N_REQ*WIDTH-1:0] wdata;
  logic [N_REQ-1:0]       gnt;
  logic                   ack;
  logic [WIDTH-1:0]       q;
  logic [IW-1:0]          owner;
  logic                   busy;

  modport master (output req, lock, wdata, input gnt, ack, q, owner, busy);
  modport slave  (input req, lock, wdata, output gnt, ack, q, owner, busy);
endinterface

// File: rtl/shared_reg_arbiter_pick.sv
// Round-robin pick: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  pick,
  output logic [IW-1:0] idx
);
  logic [2*N-1:0] masked;
  logic           found;

  // Mask the doubled vector below ptr, so the upper copy supplies the wrap.
  always_comb begin
    masked = {req, req} & ({(2*N){1'b1}} << ptr);
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < 2*N; i++) begin
      if (masked[i] && !found) begin
        found = 1'b1;
        idx   = IW'(i % N);
      end
    end
    pick = {{(N-1){1'b0}}, |req} << idx;
  end
endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter granting one writer at a time to a shared register,
// with optional locked bursts capped at MAX_BURST writes.
module shared_reg_arbiter
  import shared_reg_arbiter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic clk,
  input  logic rst_n,
  shared_reg_arbiter_if.slave bus
);
  localparam int IW = idx_w(N_REQ);
  localparam int BW = idx_w(MAX_BURST + 1);

  state_t            state, state_nx;
  logic [IW-1:0]     ptr, cur, owner_r, pick_idx, ptr_nx;
  logic [N_REQ-1:0]  gnt_r, pick;
  logic [BW-1:0]     bcnt;
  logic [WIDTH-1:0]  q_r, wsel;
  logic              ack_r, wr_en, stay;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .req  (bus.req),
    .ptr  (ptr),
    .pick (pick),
    .idx  (pick_idx)
  );

  // Granted requester's data slice and burst-continuation decision.
  always_comb begin
    wsel = '0;
    for (int i = 0; i < N_REQ; i++)
      if (cur == IW'(i)) wsel = bus.wdata[i*WIDTH +: WIDTH];
    wr_en  = (state == GRANT) && bus.req[cur];
    stay   = wr_en && bus.lock[cur] && (32'(bcnt) + 1 < MAX_BURST);
    ptr_nx = (cur == IW'(N_REQ-1)) ? '0 : cur + IW'(1);
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|bus.req) state_nx = GRANT;
      GRANT:   if (!stay)    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;

  // Grant, pointer and burst bookkeeping; ack pulses once per committed write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt_r   <= '0;
      cur     <= '0;
      ptr     <= '0;
      bcnt    <= '0;
      ack_r   <= 1'b0;
      owner_r <= '0;
    end else begin
      ack_r <= wr_en;
      if (state == IDLE) begin
        if (|bus.req) begin
          gnt_r <= pick;
          cur   <= pick_idx;
          bcnt  <= '0;
        end
      end else begin
        if (wr_en) begin
          owner_r <= cur;
          bcnt    <= bcnt + BW'(1);
        end
        if (!stay) begin
          gnt_r <= '0;
          ptr   <= ptr_nx;
        end
      end
    end
  end

  // The shared storage register, written only on a granted commit.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)     q_r <= '0;
    else if (wr_en) q_r <= wsel;

  assign bus.gnt   = gnt_r;
  assign bus.ack   = ack_r;
  assign bus.q     = q_r;
  assign bus.owner = owner_r;
  assign bus.busy  = (state != IDLE);
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter: directed scenarios plus random traffic
// compared against a behavioural model of the arbitration rules.
module tb_shared_reg_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_pass = 0, n_total = 0;

  shared_reg_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  shared_reg_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  bit         m_act;
  int         m_g, m_ptr, m_cnt, m_owner;
  logic [N-1:0] m_gnt;
  logic       m_ack;
  logic [W-1:0] m_q;

  task automatic model_reset();
    m_act = 0; m_g = 0; m_ptr = 0; m_cnt = 0; m_owner = 0;
    m_gnt = '0; m_ack = 0; m_q = '0;
  endtask

  // One clock edge of the arbitration rules, applied to the inputs before it.
  task automatic model_edge(input logic [N-1:0] r, input logic [N-1:0] l,
                            input logic [N*W-1:0] wd);
    m_ack = 0;
    if (!m_act) begin
      if (r != 0) begin
        for (int k = N-1; k >= 0; k--)
          if (r[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
        m_gnt = '0; m_gnt[m_g] = 1'b1;
        m_cnt = 0; m_act = 1;
      end
    end else if (r[m_g]) begin
      m_q = wd[m_g*W +: W]; m_ack = 1; m_owner = m_g; m_cnt++;
      if (!(l[m_g] && m_cnt < MB)) begin
        m_gnt = '0; m_ptr = (m_g + 1) % N; m_act = 0;
      end
    end else begin
      m_gnt = '0; m_ptr = (m_g + 1) % N; m_act = 0;
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    bus.req = '0; bus.lock = '0; bus.wdata = '0;
    rst_n = 1'b0; #3; rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_total++; if (bus.gnt !== 4'b0 || bus.ack !== 1'b0 || bus.busy !== 1'b0)
      $display("FAIL reset_idle: gnt=%b ack=%b busy=%b want 0", bus.gnt, bus.ack, bus.busy);
    else n_pass++;
    // start a locked burst, then reset in the middle of it
    bus.req = 4'b0010; bus.lock = 4'b0010; bus.wdata = 32'h0000_7700;
    tick(); tick(); tick();
    n_total++; if (bus.q !== 8'h77 || bus.ack !== 1'b1)
      $display("FAIL reset_pre_burst: q=%h ack=%b want 77/1", bus.q, bus.ack);
    else n_pass++;
    #2 rst_n = 1'b0; #1;
    n_total++; if (bus.gnt !== 4'b0 || bus.ack !== 1'b0 || bus.q !== 8'h00 ||
                   bus.owner !== 2'd0 || bus.busy !== 1'b0)
      $display("FAIL reset_async: gnt=%b ack=%b q=%h owner=%0d busy=%b want all 0",
               bus.gnt, bus.ack, bus.q, bus.owner, bus.busy);
    else n_pass++;
    bus.req = '0; bus.lock = '0;
    #2 rst_n = 1'b1; tick();
  endtask

  task automatic test_single();
    do_reset();
    bus.req = 4'b0100; bus.wdata = 32'h00A5_0000;
    tick();
    n_total++; if (bus.gnt !== 4'b0100 || bus.ack !== 1'b0 || bus.busy !== 1'b1)
      $display("FAIL single_gnt: gnt=%b ack=%b busy=%b want 0100/0/1", bus.gnt, bus.ack, bus.busy);
    else n_pass++;
    tick();
    bus.req = '0;
    n_total++; if (bus.q !== 8'hA5 || bus.owner !== 2'd2 || bus.ack !== 1'b1 || bus.gnt !== 4'b0)
      $display("FAIL single_commit: q=%h owner=%0d ack=%b gnt=%b want a5/2/1/0000",
               bus.q, bus.owner, bus.ack, bus.gnt);
    else n_pass++;
    tick();
    n_total++; if (bus.ack !== 1'b0 || bus.busy !== 1'b0 || bus.q !== 8'hA5)
      $display("FAIL single_after: ack=%b busy=%b q=%h want 0/0/a5", bus.ack, bus.busy, bus.q);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    do_reset();
    bus.req = 4'b1111; bus.lock = '0; bus.wdata = 32'h4433_2211;
    for (int k = 0; k < 5; k++) begin
      tick();
      n_total++; if (bus.ack !== 1'b0 || bus.gnt !== (4'b0001 << (k % 4)))
        $display("FAIL rr_gnt%0d: gnt=%b ack=%b want %b/0", k, bus.gnt, bus.ack, 4'b0001 << (k % 4));
      else n_pass++;
      tick();
      n_total++; if (bus.ack !== 1'b1 || bus.owner !== 2'(k % 4) || bus.q !== 8'(8'h11 * ((k % 4) + 1)))
        $display("FAIL rr_commit%0d: owner=%0d q=%h ack=%b want %0d", k, bus.owner, bus.q, bus.ack, k % 4);
      else n_pass++;
    end
    bus.req = '0; tick();
  endtask

  task automatic test_burst();
    do_reset();
    bus.req = 4'b1010; bus.lock = 4'b0010; bus.wdata = 32'hEE00_1000;
    tick();
    n_total++; if (bus.gnt !== 4'b0010)
      $display("FAIL burst_gnt: gnt=%b want 0010", bus.gnt);
    else n_pass++;
    for (int i = 0; i < MB; i++) begin
      bus.wdata[15:8] = 8'(8'h10 + i);
      tick();
      n_total++; if (bus.ack !== 1'b1 || bus.q !== 8'(8'h10 + i) || bus.owner !== 2'd1)
        $display("FAIL burst_w%0d: ack=%b q=%h owner=%0d want 1/%h/1", i, bus.ack, bus.q, bus.owner, 8'h10 + i);
      else n_pass++;
    end
    n_total++; if (bus.gnt !== 4'b0 || bus.busy !== 1'b0)
      $display("FAIL burst_cap: gnt=%b busy=%b want 0000/0", bus.gnt, bus.busy);
    else n_pass++;
    tick();
    n_total++; if (bus.gnt !== 4'b1000 || bus.ack !== 1'b0)
      $display("FAIL burst_next: gnt=%b ack=%b want 1000/0", bus.gnt, bus.ack);
    else n_pass++;
    bus.req = '0; bus.lock = '0; tick();
  endtask

  task automatic test_abort();
    do_reset();
    bus.req = 4'b0011; bus.wdata = 32'h0000_3C5A;
    tick();
    n_total++; if (bus.gnt !== 4'b0001)
      $display("FAIL abort_gnt: gnt=%b want 0001", bus.gnt);
    else n_pass++;
    bus.req = 4'b0010;
    tick();
    n_total++; if (bus.ack !== 1'b0 || bus.q !== 8'h00 || bus.owner !== 2'd0 || bus.busy !== 1'b0)
      $display("FAIL abort_nowrite: ack=%b q=%h owner=%0d busy=%b want 0/00/0/0",
               bus.ack, bus.q, bus.owner, bus.busy);
    else n_pass++;
    tick();
    n_total++; if (bus.gnt !== 4'b0010)
      $display("FAIL abort_next: gnt=%b want 0010", bus.gnt);
    else n_pass++;
    tick();
    n_total++; if (bus.ack !== 1'b1 || bus.owner !== 2'd1 || bus.q !== 8'h3C)
      $display("FAIL abort_commit: ack=%b owner=%0d q=%h want 1/1/3c", bus.ack, bus.owner, bus.q);
    else n_pass++;
    bus.req = '0; tick();
  endtask

  task automatic test_wrap();
    do_reset();
    bus.req = 4'b0100; bus.wdata = 32'h0D00_0000 | 32'h0000_0000;
    tick(); tick();        // requester 2 commits, pointer moves to 3
    bus.req = 4'b1001; bus.wdata = 32'hD300_00D0;
    tick();
    n_total++; if (bus.gnt !== 4'b1000)
      $display("FAIL wrap_first: gnt=%b want 1000", bus.gnt);
    else n_pass++;
    tick();
    n_total++; if (bus.owner !== 2'd3 || bus.q !== 8'hD3 || bus.ack !== 1'b1)
      $display("FAIL wrap_commit3: owner=%0d q=%h ack=%b want 3/d3/1", bus.owner, bus.q, bus.ack);
    else n_pass++;
    tick();
    n_total++; if (bus.gnt !== 4'b0001)
      $display("FAIL wrap_second: gnt=%b want 0001", bus.gnt);
    else n_pass++;
    tick();
    n_total++; if (bus.owner !== 2'd0 || bus.q !== 8'hD0)
      $display("FAIL wrap_commit0: owner=%0d q=%h want 0/d0", bus.owner, bus.q);
    else n_pass++;
    bus.req = '0; tick();
  endtask

  task automatic test_random();
    do_reset();
    model_reset();
    for (int c = 0; c < 600; c++) begin
      bus.req   = 4'($urandom) & 4'($urandom);
      if ($urandom_range(0, 3) == 0) bus.req = 4'($urandom);
      bus.lock  = 4'($urandom);
      bus.wdata = 32'($urandom);
      model_edge(bus.req, bus.lock, bus.wdata);
      tick();
      n_total++; if (bus.gnt !== m_gnt)
        $display("FAIL rnd_gnt c%0d: got %b want %b", c, bus.gnt, m_gnt);
      else n_pass++;
      n_total++; if (bus.ack !== m_ack)
        $display("FAIL rnd_ack c%0d: got %b want %b", c, bus.ack, m_ack);
      else n_pass++;
      n_total++; if (bus.q !== m_q)
        $display("FAIL rnd_q c%0d: got %h want %h", c, bus.q, m_q);
      else n_pass++;
      n_total++; if (bus.owner !== 2'(m_owner))
        $display("FAIL rnd_owner c%0d: got %0d want %0d", c, bus.owner, m_owner);
      else n_pass++;
      n_total++; if (bus.busy !== m_act)
        $display("FAIL rnd_busy c%0d: got %b want %b", c, bus.busy, m_act);
      else n_pass++;
    end
  endtask

  initial begin
    bus.req = '0; bus.lock = '0; bus.wdata = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_burst();
    test_abort();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/shared_reg_arbiter.md
# shared_reg_arbiter

Round-robin write arbiter that shares one WIDTH-bit storage register among N_REQ requesters. Each requester raises a request with its write data. The block grants one requester at a time, commits that requester's data into the shared register and acknowledges the write. An optional lock lets a requester burst several writes, capped at MAX_BURST. It sits in front of the design's flip-flop storage and is the only writer of that register.

## Interface
Parameters:
- N_REQ, 4, number of requesters (2..8)
- WIDTH, 8, shared register width
- MAX_BURST, 4, max consecutive writes per grant under lock (>=1)

Ports:
- clk  input  1  single clock, rising-edge
- rst_n  input  1  asynchronous, active-low reset
- req  input  N_REQ  per-requester write request, level
- lock  input  N_REQ  per-requester burst hold, qualified by req
- wdata  input  N_REQ*WIDTH  packed write data; slice i = wdata[i*WIDTH +: WIDTH]
- gnt  output  N_REQ  one-hot grant, registered
- ack  output  1  one-cycle pulse, write committed
- q  output  WIDTH  shared register contents
- owner  output  clog2(N_REQ)  index of last committed writer
- busy  output  1  high when state != IDLE

## Operation
- States: IDLE, GRANT.
- IDLE:
  - If req != 0, pick winner g = first set bit of req searching upward from ptr, wrapping.
  - gnt <= onehot(g), burst count <= 0, go to GRANT.
  - If req == 0, stay in IDLE, gnt = 0.
- GRANT, req[g] = 1:
  - q <= wdata slice g, ack <= 1, owner <= g, burst count += 1.
  - Stay in GRANT if lock[g] = 1 and count+1 < MAX_BURST.
  - Otherwise gnt <= 0, ptr <= (g+1) mod N_REQ, go to IDLE.
- GRANT, req[g] = 0 (abort):
  - No write, no ack, q and owner unchanged.
  - gnt <= 0, ptr <= (g+1) mod N_REQ, go to IDLE.
- Requests from non-granted requesters are ignored while in GRANT; they compete at the next IDLE.
- lock without req has no effect.
- Reset values: state = IDLE, ptr = 0, gnt = 0, ack = 0, q = 0, owner = 0, busy = 0, burst count = 0.
- rst_n assertion mid-burst clears everything immediately; no partial write survives.

## Timing
- Request to grant:
  - req sampled at edge E0 in IDLE; gnt visible after E0.
  - Write occurs at E1; q, owner and ack update together after E1.
  - Request-to-commit latency: 2 edges.
- ack:
  - Single write: high exactly one cycle.
  - Locked burst: ack stays high on consecutive cycles, one cycle per write, with q updating each cycle.
- Minimum gap between grants: one IDLE cycle. Sustained single-write throughput is 1 write per 2 cycles; locked burst is 1 write per cycle.
- The requester must hold wdata stable from the gnt rise through the commit edge.
- Fairness: worst-case wait for an active requester is (N_REQ-1)*(MAX_BURST+1) cycles.
- Pointer wrap: g = N_REQ-1 yields ptr = 0.

## Structure
- Package shared_reg_arbiter_pkg:
  - state enum {IDLE, GRANT}
  - localparam function for clog2 index width
  - default MAX_BURST constant
- Sub-module rr_pick (combinational): inputs req and ptr; outputs one-hot pick and binary index. Implemented as a double-width masked priority encoder.
- Top module holds the FSM, ptr, burst counter, gnt/ack/owner registers and the enabled q register.

## Test plan
- Reset: drive rst_n=0 mid-operation -> gnt=0, ack=0, q=8'h00, owner=0, busy=0 immediately.
- Single write: req=4'b0100, wdata slice2=8'hA5 -> gnt=4'b0100 after E0; q=8'hA5, owner=2, ack=1 for one cycle after E1; then IDLE.
- Round-robin: req=4'b1111 held, lock=0 -> commits in order owner 0,1,2,3,0, each 2 cycles apart.
- Locked burst cap: req[1]=1, lock[1]=1, MAX_BURST=4, slice1 increments 8'h10..8'h13 each cycle -> 4 consecutive acks, q ends 8'h13, then release. With req[3] also pending, the next grant goes to requester 3.
- Abort: grant requester 0, then drop req[0] before E1 -> no ack, q unchanged, ptr=1; the next grant goes to requester 1 if requesting.
- Wrap: ptr=3, req=4'b1001 -> requester 3 granted first, then requester 0.
